// File: rtl/riscv_core_div_pkg.sv
// Shared types and helpers for the RISC-V M-extension divide controller.
// Contents: op and FSM state enums, most-negative constants, and small
// negate / sign-extend helpers used by the datapath.
package riscv_core_div_pkg;

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_FIX,
        ST_RESP,
        ST_DRAIN
    } div_state_e;

    localparam logic [63:0] MIN_NEG64 = 64'h8000_0000_0000_0000;
    // W-op most-negative value as it appears after sign extension to 64 bits.
    localparam logic [63:0] MIN_NEG32 = 64'hFFFF_FFFF_8000_0000;

    function automatic logic [63:0] cond_neg(input logic [63:0] v, input logic en);
        return en ? (~v + 64'd1) : v;
    endfunction

    function automatic logic [63:0] sext32(input logic [63:0] v);
        return {{32{v[31]}}, v[31:0]};
    endfunction

endpackage

// File: rtl/riscv_core_div_sign_fix.sv
// Combinational sign handling around the unsigned divider core.
// Front side (IDLE): W-extends operands, produces magnitudes and result signs.
//   rs1/rs2, word, signed_op -> ext_a/ext_b, mag_a/mag_b, neg_q/neg_r
// Back side (FIX): applies sign correction and W sign-extension.
//   quo/rem, fix_neg_q/fix_neg_r, fix_word -> fin_q/fin_r
module riscv_core_div_sign_fix
    import riscv_core_div_pkg::*;
(
    input  logic [63:0] rs1,
    input  logic [63:0] rs2,
    input  logic        word,
    input  logic        signed_op,
    output logic [63:0] ext_a,
    output logic [63:0] ext_b,
    output logic [63:0] mag_a,
    output logic [63:0] mag_b,
    output logic        neg_q,
    output logic        neg_r,
    input  logic [63:0] quo,
    input  logic [63:0] rem,
    input  logic        fix_neg_q,
    input  logic        fix_neg_r,
    input  logic        fix_word,
    output logic [63:0] fin_q,
    output logic [63:0] fin_r
);

    logic        sa;
    logic        sb;
    logic [63:0] q_n;
    logic [63:0] r_n;

    always_comb begin
        if (word) begin
            ext_a = signed_op ? sext32(rs1) : {32'b0, rs1[31:0]};
            ext_b = signed_op ? sext32(rs2) : {32'b0, rs2[31:0]};
        end else begin
            ext_a = rs1;
            ext_b = rs2;
        end
        sa    = signed_op & ext_a[63];
        sb    = signed_op & ext_b[63];
        mag_a = cond_neg(ext_a, sa);
        mag_b = cond_neg(ext_b, sb);
        neg_q = sa ^ sb;
        neg_r = sa;

        q_n   = cond_neg(quo, fix_neg_q);
        r_n   = cond_neg(rem, fix_neg_r);
        // W results always take bit 31 as sign, unsigned W variants included.
        fin_q = fix_word ? sext32(q_n) : q_n;
        fin_r = fix_word ? sext32(r_n) : r_n;
    end

endmodule

// File: rtl/riscv_core_div_ctrl.sv
// RISC-V DIV/DIVU/REM/REMU (+W) control around an unsigned non-restoring core.
// Request:  i_div_valid/o_div_ready, i_div_op, i_div_word, i_div_rs1/rs2, i_div_kill
// Response: o_div_valid/i_div_resp_ready, o_div_result
// Core:     o_core_en (1-cycle start), o_core_dividend/divisor (held until done),
//           i_core_done, i_core_quotient/remainder
// Optional: RISCV_DIV_PAIR_BYPASS_EN adds a one-entry result cache so a
//           DIV/REM pair on identical operands skips the second core op.
module riscv_core_div_ctrl
    import riscv_core_div_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            i_non_restoring_clk,
    input  logic            i_non_restoring_rstn,
    input  logic            i_div_valid,
    output logic            o_div_ready,
    input  logic [1:0]      i_div_op,
    input  logic            i_div_word,
    input  logic [XLEN-1:0] i_div_rs1,
    input  logic [XLEN-1:0] i_div_rs2,
    input  logic            i_div_kill,
    output logic            o_div_valid,
    input  logic            i_div_resp_ready,
    output logic [XLEN-1:0] o_div_result,
    output logic            o_core_en,
    output logic [XLEN-1:0] o_core_dividend,
    output logic [XLEN-1:0] o_core_divisor,
    input  logic            i_core_done,
    input  logic [XLEN-1:0] i_core_quotient,
    input  logic [XLEN-1:0] i_core_remainder
);

    div_state_e  state_q, state_d;
    div_op_e     op_q;
    logic        word_q;
    logic        neg_q_q, neg_r_q;
    logic [63:0] mag_a_q, mag_b_q;
    logic [63:0] quo_q, rem_q;
    logic [63:0] result_q;

    logic        signed_in;
    logic [63:0] ext_a, ext_b, mag_a, mag_b;
    logic        neg_q, neg_r;
    logic [63:0] fin_q, fin_r, fix_res;
    logic        accept, div_zero, ovf, special;
    logic [63:0] spec_q, spec_r, spec_sel, spec_res;
    logic        hit;
    logic [63:0] hit_res;

    assign signed_in = ~i_div_op[0];
    assign accept    = (state_q == ST_IDLE) && i_div_valid;

    riscv_core_div_sign_fix u_sign_fix (
        .rs1       (i_div_rs1),
        .rs2       (i_div_rs2),
        .word      (i_div_word),
        .signed_op (signed_in),
        .ext_a     (ext_a),
        .ext_b     (ext_b),
        .mag_a     (mag_a),
        .mag_b     (mag_b),
        .neg_q     (neg_q),
        .neg_r     (neg_r),
        .quo       (quo_q),
        .rem       (rem_q),
        .fix_neg_q (neg_q_q),
        .fix_neg_r (neg_r_q),
        .fix_word  (word_q),
        .fin_q     (fin_q),
        .fin_r     (fin_r)
    );

    assign fix_res = op_q[1] ? fin_r : fin_q;

    // ISA special cases, resolved without the core. ext_b is already
    // W-extended, so a zero low word shows up as a zero divisor here.
    always_comb begin
        div_zero = (ext_b == 64'd0);
        ovf      = signed_in && (ext_b == '1) &&
                   (ext_a == (i_div_word ? MIN_NEG32 : MIN_NEG64));
        special  = div_zero | ovf;
        spec_q   = div_zero ? '1 : ext_a;
        spec_r   = div_zero ? ext_a : 64'd0;
        spec_sel = i_div_op[1] ? spec_r : spec_q;
        spec_res = i_div_word ? sext32(spec_sel) : spec_sel;
    end

`ifdef RISCV_DIV_PAIR_BYPASS_EN
    logic        c_vld;
    logic [63:0] c_rs1, c_rs2, c_q, c_r;
    logic        c_signed, c_word;
    logic [63:0] rs1_q, rs2_q;
    logic        signed_q;

    assign hit = c_vld && !special && (c_rs1 == i_div_rs1) && (c_rs2 == i_div_rs2) &&
                 (c_signed == signed_in) && (c_word == i_div_word);
    assign hit_res = i_div_op[1] ? c_r : c_q;

    always_ff @(posedge i_non_restoring_clk or negedge i_non_restoring_rstn) begin
        if (!i_non_restoring_rstn) begin
            c_vld    <= 1'b0;
            c_rs1    <= '0;
            c_rs2    <= '0;
            c_q      <= '0;
            c_r      <= '0;
            c_signed <= 1'b0;
            c_word   <= 1'b0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            signed_q <= 1'b0;
        end else begin
            if (accept) begin
                rs1_q    <= i_div_rs1;
                rs2_q    <= i_div_rs2;
                signed_q <= signed_in;
            end
            if (i_div_kill && state_q != ST_IDLE) begin
                c_vld <= 1'b0;
            end else if (accept && special) begin
                c_vld <= 1'b0;
            end else if (state_q == ST_FIX) begin
                c_vld    <= 1'b1;
                c_rs1    <= rs1_q;
                c_rs2    <= rs2_q;
                c_signed <= signed_q;
                c_word   <= word_q;
                c_q      <= fin_q;
                c_r      <= fin_r;
            end
        end
    end
`else
    assign hit     = 1'b0;
    assign hit_res = '0;
`endif

    always_ff @(posedge i_non_restoring_clk or negedge i_non_restoring_rstn) begin
        if (!i_non_restoring_rstn) state_q <= ST_IDLE;
        else                       state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        o_div_ready = 1'b0;
        o_div_valid = 1'b0;
        o_core_en   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                o_div_ready = 1'b1;
                if (i_div_valid) state_d = (special || hit) ? ST_RESP : ST_ISSUE;
            end
            ST_ISSUE: begin
                if (i_div_kill) begin
                    state_d = ST_IDLE;
                end else begin
                    o_core_en = 1'b1;
                    state_d   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A done arriving with the kill retires the core op, so
                // there is nothing left to drain.
                if (i_div_kill)       state_d = i_core_done ? ST_IDLE : ST_DRAIN;
                else if (i_core_done) state_d = ST_FIX;
            end
            ST_FIX:   state_d = i_div_kill ? ST_IDLE : ST_RESP;
            ST_RESP: begin
                if (i_div_kill) begin
                    state_d = ST_IDLE;
                end else begin
                    o_div_valid = 1'b1;
                    if (i_div_resp_ready) state_d = ST_IDLE;
                end
            end
            ST_DRAIN: if (i_core_done) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_non_restoring_clk or negedge i_non_restoring_rstn) begin
        if (!i_non_restoring_rstn) begin
            op_q     <= OP_DIV;
            word_q   <= 1'b0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            mag_a_q  <= '0;
            mag_b_q  <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            result_q <= '0;
        end else begin
            if (accept) begin
                op_q    <= div_op_e'(i_div_op);
                word_q  <= i_div_word;
                neg_q_q <= neg_q;
                neg_r_q <= neg_r;
                mag_a_q <= mag_a;
                mag_b_q <= mag_b;
                if (special)  result_q <= spec_res;
                else if (hit) result_q <= hit_res;
            end
            if (state_q == ST_WAIT && i_core_done) begin
                quo_q <= i_core_quotient;
                rem_q <= i_core_remainder;
            end
            if (state_q == ST_FIX && !i_div_kill) result_q <= fix_res;
        end
    end

    assign o_core_dividend = mag_a_q;
    assign o_core_divisor  = mag_b_q;
    assign o_div_result    = result_q;

endmodule

// File: tb/tb_riscv_core_div_ctrl.sv
module tb_riscv_core_div_ctrl;

    localparam int LAT = 4;
`ifdef RISCV_DIV_PAIR_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstn;
    logic        div_valid, div_ready, div_word, div_kill, div_valid_o, resp_ready;
    logic [1:0]  div_op;
    logic [63:0] rs1, rs2, result;
    logic        core_en, core_done;
    logic [63:0] core_a, core_b, core_q, core_r;

    int total = 0;
    int bad   = 0;
    int en_cnt = 0;
    bit done_seen;

    always #5 clk = ~clk;

    riscv_core_div_ctrl #(.XLEN(64)) dut (
        .i_non_restoring_clk  (clk),
        .i_non_restoring_rstn (rstn),
        .i_div_valid          (div_valid),
        .o_div_ready          (div_ready),
        .i_div_op             (div_op),
        .i_div_word           (div_word),
        .i_div_rs1            (rs1),
        .i_div_rs2            (rs2),
        .i_div_kill           (div_kill),
        .o_div_valid          (div_valid_o),
        .i_div_resp_ready     (resp_ready),
        .o_div_result         (result),
        .o_core_en            (core_en),
        .o_core_dividend      (core_a),
        .o_core_divisor       (core_b),
        .i_core_done          (core_done),
        .i_core_quotient      (core_q),
        .i_core_remainder     (core_r)
    );

    // Unsigned divider core model: done LAT cycles after the start pulse.
    logic        busy;
    int          cnt;
    logic [63:0] ca, cb;
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busy <= 1'b0; cnt <= 0; ca <= '0; cb <= '0;
            core_done <= 1'b0; core_q <= '0; core_r <= '0;
        end else begin
            core_done <= 1'b0;
            if (core_done) done_seen <= 1'b1;
            if (core_en) en_cnt <= en_cnt + 1;
            if (core_en) begin
                busy <= 1'b1; cnt <= LAT; ca <= core_a; cb <= core_b;
            end else if (busy) begin
                if (cnt == 1) begin
                    busy      <= 1'b0;
                    core_done <= 1'b1;
                    core_q    <= (cb == 0) ? '1 : ca / cb;
                    core_r    <= (cb == 0) ? ca : ca % cb;
                end
                cnt <= cnt - 1;
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Called at a negedge; returns just after the accepting posedge.
    task automatic send(input logic [1:0] op, input logic w, input logic [63:0] a, input logic [63:0] b);
        int g = 0;
        while (!div_ready && g < 100) begin @(negedge clk); g++; end
        chk("ready_before_send", {63'd0, div_ready}, 64'd1);
        div_valid = 1'b1; div_op = op; div_word = w; rs1 = a; rs2 = b;
        @(posedge clk); #1;
        div_valid = 1'b0;
    endtask

    task automatic wait_valid(input string nm, output int cyc);
        bit ok = 0;
        cyc = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk); cyc++;
            if (div_valid_o) begin ok = 1; break; end
        end
        chk({nm, "_valid_seen"}, {63'd0, ok}, 64'd1);
    endtask

    task automatic take_resp();
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        @(negedge clk);
    endtask

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic        w;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        bit          spec;
        bit          pair;
    } vec_t;

    vec_t vt[14];

    initial begin
        int cyc, e0, exp_en, ok_flag;
        logic [63:0] r0;

        vt[0]  = '{"div_m7_2",    2'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 0, 0};
        vt[1]  = '{"rem_m7_2",    2'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1};
        vt[2]  = '{"divu_by0",    2'd1, 1'b0, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0};
        vt[3]  = '{"remu_by0",    2'd3, 1'b0, 64'h1234, 64'd0, 64'h1234, 1, 0};
        vt[4]  = '{"div_ovf64",   2'd0, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1, 0};
        vt[5]  = '{"remw_ovf",    2'd2, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'd0, 1, 0};
        vt[6]  = '{"divuw_sext",  2'd1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0};
        vt[7]  = '{"divw_m7_2",   2'd0, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'hABCD_0000_0000_0002, 64'hFFFF_FFFF_FFFF_FFFD, 0, 0};
        vt[8]  = '{"remu_max_10", 2'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd10, 64'd5, 0, 0};
        vt[9]  = '{"divu_max_2",  2'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'h7FFF_FFFF_FFFF_FFFF, 0, 0};
        vt[10] = '{"rem_7_m2",    2'd2, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 0, 0};
        vt[11] = '{"remw_by0",    2'd2, 1'b1, 64'h1111_1111_8000_0001, 64'h2222_2222_0000_0000, 64'hFFFF_FFFF_8000_0001, 1, 0};
        vt[12] = '{"div_100_7",   2'd0, 1'b0, 64'd100, 64'd7, 64'd14, 0, 0};
        vt[13] = '{"rem_100_7",   2'd2, 1'b0, 64'd100, 64'd7, 64'd2, 0, 1};

        rstn = 1'b0; div_valid = 0; div_op = 0; div_word = 0; rs1 = 0; rs2 = 0;
        div_kill = 0; resp_ready = 0; done_seen = 0;
        repeat (3) @(negedge clk);
        chk("rst_ready",  {63'd0, div_ready},   64'd1);
        chk("rst_valid",  {63'd0, div_valid_o}, 64'd0);
        chk("rst_core_en",{63'd0, core_en},     64'd0);
        chk("rst_result", result, 64'd0);
        chk("rst_dividend", core_a, 64'd0);
        rstn = 1'b1;
        @(negedge clk);

        foreach (vt[i]) begin
            e0 = en_cnt;
            send(vt[i].op, vt[i].w, vt[i].a, vt[i].b);
            wait_valid(vt[i].name, cyc);
            chk(vt[i].name, result, vt[i].exp);
            take_resp();
            exp_en = (vt[i].spec || (vt[i].pair && BYP)) ? 0 : 1;
            chk({vt[i].name, "_en_cnt"}, 64'(en_cnt - e0), 64'(exp_en));
            if (exp_en == 0) chk({vt[i].name, "_latency"}, 64'(cyc), 64'd1);
        end

        // Kill during WAIT: no response, ready only after the core finishes.
        done_seen = 0;
        send(2'd0, 1'b0, 64'd1000, 64'd3);
        @(negedge clk); @(negedge clk);
        div_kill = 1'b1;
        @(posedge clk); #1;
        div_kill = 1'b0;
        begin
            bit vbad = 0, early = 0, rdy = 0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (div_valid_o) vbad = 1;
                if (div_ready) begin
                    rdy = 1;
                    if (!done_seen) early = 1;
                    break;
                end
            end
            chk("kwait_ready_back", {63'd0, rdy},   64'd1);
            chk("kwait_no_valid",   {63'd0, vbad},  64'd0);
            chk("kwait_not_early",  {63'd0, early}, 64'd0);
        end
        send(2'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2);
        wait_valid("after_kill", cyc);
        chk("after_kill_div", result, 64'hFFFF_FFFF_FFFF_FFFD);
        take_resp();

        // Kill in ISSUE: start pulse suppressed, straight back to idle.
        e0 = en_cnt;
        send(2'd1, 1'b0, 64'd555, 64'd5);
        div_kill = 1'b1;
        #1;
        chk("kissue_no_en", {63'd0, core_en}, 64'd0);
        @(posedge clk); #1;
        div_kill = 1'b0;
        @(negedge clk);
        chk("kissue_ready", {63'd0, div_ready}, 64'd1);
        repeat (LAT + 2) @(negedge clk);
        chk("kissue_en_cnt", 64'(en_cnt - e0), 64'd0);
        chk("kissue_no_valid", {63'd0, div_valid_o}, 64'd0);

        // Backpressure: result held, ready low while waiting for consumer.
        send(2'd1, 1'b0, 64'h1234, 64'd0);
        wait_valid("hold", cyc);
        r0 = result;
        ok_flag = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (!div_valid_o || div_ready || result !== 64'hFFFF_FFFF_FFFF_FFFF) ok_flag = 0;
        end
        chk("hold_first", r0, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("hold_stable", 64'(ok_flag), 64'd1);
        take_resp();

        // Kill and resp_ready together in RESP: kill wins.
        send(2'd3, 1'b0, 64'h1234, 64'd0);
        wait_valid("kresp", cyc);
        div_kill = 1'b1; resp_ready = 1'b1;
        #1;
        chk("kresp_valid_masked", {63'd0, div_valid_o}, 64'd0);
        @(posedge clk); #1;
        div_kill = 1'b0; resp_ready = 1'b0;
        @(negedge clk);
        chk("kresp_idle", {62'd0, div_ready, div_valid_o}, 64'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: sim time exceeded, bad=%0d", bad);
        $fatal(1);
    end

endmodule

// File: doc/riscv_core_div_ctrl.md
Name: riscv_core_div_ctrl

Overview:
RISC-V M-extension divide front/back end for DIV, DIVU, REM, REMU and the W variants (DIVW, DIVUW, REMW, REMUW).
- Upstream: accepts operands from the execute stage and converts signed operands to magnitudes.
- Core: issues the magnitudes to the unsigned non-restoring divider core, which has a one-cycle start pulse and a done strobe.
- Downstream: applies sign correction, W truncation/sign-extension and ISA special-case results, then returns the result over a valid/ready handshake.

Parameters:
XLEN, 64, datapath width. Only 64 is supported; W ops use the low 32 bits.

Ports:
i_non_restoring_clk  in  1  clock
i_non_restoring_rstn  in  1  asynchronous, active-low reset
i_div_valid  in  1  request valid
o_div_ready  out  1  ready to accept; high only in IDLE
i_div_op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
i_div_word  in  1  1 = W variant
i_div_rs1  in  XLEN  dividend
i_div_rs2  in  XLEN  divisor
i_div_kill  in  1  pipeline flush; drop the in-flight op
o_div_valid  out  1  result valid
i_div_resp_ready  in  1  consumer accepts the result
o_div_result  out  XLEN  result
o_core_en  out  1  one-cycle start pulse to the core
o_core_dividend  out  XLEN  unsigned dividend magnitude
o_core_divisor  out  XLEN  unsigned divisor magnitude
i_core_done  in  1  core done strobe
i_core_quotient  in  XLEN  core quotient
i_core_remainder  in  XLEN  core remainder

Behaviour:
- Reset values: all outputs 0 except o_div_ready = 1; state IDLE; all registers 0.
- States: IDLE, ISSUE, WAIT, FIX, RESP, DRAIN.
- IDLE: a request is accepted when i_div_valid && o_div_ready. On acceptance, latch op, word, operands and signed = ~op[0].
  - W ops: operands become the low 32 bits, sign- or zero-extended to 64 per signedness.
  - Magnitudes: negate negative operands (two's complement) when signed.
  - Record neg_q = sign(rs1) ^ sign(rs2) and neg_r = sign(rs1).
- Special cases are decided in IDLE and bypass the core (next state RESP):
  - Divisor == 0: quotient = all-ones, remainder = dividend.
  - Signed overflow (dividend = most-negative, divisor = -1, at 64 or 32 bits per word): quotient = dividend, remainder = 0.
  - Both results are still subject to the W sign-extension rule.
- ISSUE: o_core_en = 1 for exactly one cycle with the magnitudes stable, then go to WAIT. The magnitudes are held stable until done.
- WAIT: on i_core_done, latch quotient and remainder, then go to FIX.
- FIX: one cycle.
  - Negate the quotient if neg_q; negate the remainder if neg_r.
  - Select quotient or remainder by op[1].
  - W ops: sign-extend bit 31 to 64 (applies to DIVUW/REMUW as well).
  - Register the result, then go to RESP.
- RESP: o_div_valid = 1 and o_div_result held stable until i_div_resp_ready; then go to IDLE.
- Latency: special case, o_div_valid on the 2nd cycle after acceptance. Normal ops: acceptance, then ISSUE, then core latency, then FIX, then RESP; that is core latency + 3 cycles.
- Kill handling:
  - Kill in ISSUE or RESP: go to IDLE with no response. A kill in ISSUE suppresses o_core_en.
  - Kill in WAIT or FIX: the core cannot be aborted, so go to DRAIN, wait for i_core_done, then go to IDLE with nothing emitted. The FIX case already has done, so it goes straight to IDLE.
  - Kill in IDLE is ignored.
  - Kill and resp_ready asserted in the same cycle: kill wins, result dropped.
- Reset mid-operation: return to IDLE immediately. The core is reset by the same reset.
- i_core_done outside WAIT/DRAIN is ignored.

Optional Feature:
Macro: RISCV_DIV_PAIR_BYPASS_EN.
- Defined: keep a one-entry cache of the last completed core op: rs1, rs2, signed, word, final quotient and final remainder, plus a valid bit.
  - A new request with identical rs1/rs2/signed/word hits the cache (the DIV-then-REM pair). A hit goes straight to RESP with the other result, giving a 2-cycle latency and issuing no core op.
  - The cache valid bit is cleared on reset, on kill, and on any special-case op.
- Undefined: no cache; every op uses the core.

Decomposition:
- Package riscv_core_div_pkg: div_op_e (DIV, DIVU, REM, REMU), state enum, the MIN_NEG64/MIN_NEG32 constants, and a function for conditional two's-complement negation.
- One natural sub-module, riscv_core_div_sign_fix: purely combinational magnitude and sign-correction logic used in the IDLE and FIX stages.

Test Plan:
- DIV with rs1 = -7, rs2 = 2 -> result 0xFFFF_FFFF_FFFF_FFFD (-3); REM with the same operands -> 0xFFFF_FFFF_FFFF_FFFF (-1); exactly one o_core_en pulse per op.
- DIVU with rs2 = 0, rs1 = 0x1234 -> result all-ones with no o_core_en; REMU with the same operands -> 0x1234; o_div_valid on the 2nd cycle after acceptance.
- DIV with 0x8000_0000_0000_0000 / -1 -> 0x8000_0000_0000_0000; REMW with 0x8000_0000 / 0xFFFF_FFFF -> 0.
- DIVUW with rs1 = 0xFFFF_FFFF_FFFF_FFFE, rs2 = 1 -> 0xFFFF_FFFF_FFFF_FFFE (bit 31 sign-extended).
- Kill during WAIT -> no o_div_valid; o_div_ready returns only after i_core_done; the next op then completes correctly.
- Hold i_div_resp_ready low for 5 cycles -> result stable and o_div_ready low throughout. With RISCV_DIV_PAIR_BYPASS_EN, DIV 100/7 then REM 100/7 -> 14 then 2, with the second op issuing no o_core_en.
